// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: steers datapath accesses to dmem or on-chip I/O registers
// (LED, debounced switches, 7-seg, cycle counter, status) and muxes read data back.
module mmio_io_ctrl #(
  parameter int              N          = 64,
  parameter logic [N-1:0]    LED_ADDR   = 64'h8000,
  parameter logic [N-1:0]    SW_ADDR    = 64'h8008,
  parameter logic [N-1:0]    SEG_ADDR   = 64'h8010,
  parameter logic [N-1:0]    CNT_ADDR   = 64'h8018,
  parameter logic [N-1:0]    STAT_ADDR  = 64'h8020,
  parameter int              DEB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] addr,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [N-1:0] wr_data,
  input  logic [N-1:0] mem_rd_data,
  input  logic [15:0]  sw_in,
  output logic         mem_wr_en,
  output logic         mem_rd_en,
  output logic [N-1:0] rd_data,
  output logic [15:0]  led,
  output logic [15:0]  seg_bcd,
  output logic [3:0]   seg_blank
);

  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [15:0]   led_q, led_d;
  logic [19:0]   seg_q, seg_d;
  logic [15:0]   sync1_q, sync1_d;
  logic [15:0]   sw_sync_q, sw_sync_d;
  logic [15:0]   sw_stable_q, sw_stable_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic          sw_changed_q, sw_changed_d;

  logic hit_led, hit_sw, hit_seg, hit_cnt, hit_stat, io_hit;
  logic sw_accept, stat_clr;

  always_comb begin
    hit_led   = (addr == LED_ADDR);
    hit_sw    = (addr == SW_ADDR);
    hit_seg   = (addr == SEG_ADDR);
    hit_cnt   = (addr == CNT_ADDR);
    hit_stat  = (addr == STAT_ADDR);
    io_hit    = hit_led | hit_sw | hit_seg | hit_cnt | hit_stat;
    mem_wr_en = wr_en & ~io_hit;
    mem_rd_en = rd_en & ~io_hit;
  end

  always_comb begin
    if (hit_led) begin
      rd_data = N'(led_q);
    end else if (hit_sw) begin
      rd_data = N'(sw_stable_q);
    end else if (hit_seg) begin
      rd_data = N'(seg_q);
    end else if (hit_cnt) begin
      rd_data = cnt_q;
    end else if (hit_stat) begin
      rd_data = N'(sw_changed_q);
    end else begin
      rd_data = mem_rd_data;
    end
  end

  // Debounce: count only while the synchronized value differs from the accepted one.
  always_comb begin
    sync1_d     = sw_in;
    sw_sync_d   = sync1_q;
    sw_stable_d = sw_stable_q;
    deb_cnt_d   = deb_cnt_q;
    sw_accept   = 1'b0;
    if (sw_sync_q == sw_stable_q) begin
      deb_cnt_d = {DW{1'b0}};
    end else if (deb_cnt_q == DEB_LAST) begin
      sw_stable_d = sw_sync_q;
      deb_cnt_d   = {DW{1'b0}};
      sw_accept   = 1'b1;
    end else begin
      deb_cnt_d = deb_cnt_q + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    if (wr_en && hit_led) begin
      led_d = wr_data[15:0];
    end else begin
      led_d = led_q;
    end
    if (wr_en && hit_seg) begin
      seg_d = wr_data[19:0];
    end else begin
      seg_d = seg_q;
    end
    if (wr_en && hit_cnt) begin
      cnt_d = wr_data;
    end else begin
      cnt_d = cnt_q + {{(N-1){1'b0}}, 1'b1};
    end
    stat_clr = wr_en & hit_stat & wr_data[0];
    // Set beats clear when both land on the same edge.
    if (sw_accept) begin
      sw_changed_d = 1'b1;
    end else if (stat_clr) begin
      sw_changed_d = 1'b0;
    end else begin
      sw_changed_d = sw_changed_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q        <= 16'h0000;
      seg_q        <= 20'hF0000;
      sync1_q      <= 16'h0000;
      sw_sync_q    <= 16'h0000;
      sw_stable_q  <= 16'h0000;
      deb_cnt_q    <= {DW{1'b0}};
      cnt_q        <= {N{1'b0}};
      sw_changed_q <= 1'b0;
    end else begin
      led_q        <= led_d;
      seg_q        <= seg_d;
      sync1_q      <= sync1_d;
      sw_sync_q    <= sw_sync_d;
      sw_stable_q  <= sw_stable_d;
      deb_cnt_q    <= deb_cnt_d;
      cnt_q        <= cnt_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign led       = led_q;
  assign seg_bcd   = seg_q[15:0];
  assign seg_blank = seg_q[19:16];

endmodule
